// File: rtl/parking_pkg.sv
`default_nettype none
// parking_pkg: shared gate state encoding, car park constants and default lane timing.
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_OPEN  = 3'd2,
    ST_PULSE = 3'd3,
    ST_CLOSE = 3'd4,
    ST_DENY  = 3'd5
  } gate_state_e;

  localparam int PARK_CLOCKS_IN_HOUR = 500;
  localparam int PARK_TOTAL_CAPACITY = 700;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_TAG_TIMEOUT     = 1000;
  localparam int DEF_OPEN_TIMEOUT    = 5000;
  localparam int DEF_PULSE_CYCLES    = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// sensor_debounce: 2-flop synchronizer followed by a consecutive-disagreement debounce counter.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic db_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic          db_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any sample that agrees with the current output restarts the count.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign db_o = db_q;

endmodule
`default_nettype wire

// File: rtl/parking_gate.sv
`default_nettype none
// parking_gate: lane barrier controller producing the occupancy counter's car pulse and class bit.
module parking_gate
  import parking_pkg::*;
#(
  parameter bit IS_EXIT         = 1'b0,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TAG_TIMEOUT     = DEF_TAG_TIMEOUT,
  parameter int OPEN_TIMEOUT    = DEF_OPEN_TIMEOUT,
  parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       loop_raw,
  input  logic       pass_raw,
  input  logic       tag_valid,
  input  logic       tag_is_uni,
  input  logic       space_uni,
  input  logic       space_free,
  output logic       barrier_open,
  output logic       car_pulse,
  output logic       car_is_uni,
  output logic       denied,
  output logic       timeout_err,
  output logic       tailgate,
  output logic [2:0] state_o
);

  localparam int TMAX = max3(TAG_TIMEOUT, OPEN_TIMEOUT, PULSE_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TAG_LAST   = TW'(TAG_TIMEOUT - 1);
  localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_TIMEOUT - 1);
  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);

  logic          loop_db;
  logic          pass_db;
  logic          pass_rise;
  logic          admit;
  logic [TW-1:0] timer_d;

  gate_state_e   state_q;
  logic [TW-1:0] timer_q;
  logic          pass_prev_q;
  logic          barrier_open_q;
  logic          car_pulse_q;
  logic          car_is_uni_q;
  logic          denied_q;
  logic          timeout_err_q;
  logic          tailgate_q;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_loop_db (
    .clock (clock),
    .reset (reset),
    .raw_i (loop_raw),
    .db_o  (loop_db)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pass_db (
    .clock (clock),
    .reset (reset),
    .raw_i (pass_raw),
    .db_o  (pass_db)
  );

  assign pass_rise = pass_db && !pass_prev_q;
  assign admit     = IS_EXIT || (tag_is_uni ? space_uni : space_free);
  assign timer_d   = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;

  // Every transition clears the timer; otherwise it counts up and saturates.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      pass_prev_q    <= 1'b0;
      barrier_open_q <= 1'b0;
      car_pulse_q    <= 1'b0;
      car_is_uni_q   <= 1'b0;
      denied_q       <= 1'b0;
      timeout_err_q  <= 1'b0;
      tailgate_q     <= 1'b0;
    end else begin
      pass_prev_q   <= pass_db;
      timeout_err_q <= 1'b0;
      tailgate_q    <= pass_rise && (state_q != ST_OPEN);
      timer_q       <= timer_d;
      case (state_q)
        ST_IDLE: begin
          if (loop_db) begin
            state_q <= ST_CHECK;
            timer_q <= '0;
          end
        end
        ST_CHECK: begin
          if (!loop_db) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
          end else if (tag_valid) begin
            car_is_uni_q <= tag_is_uni;
            timer_q      <= '0;
            if (admit) begin
              state_q        <= ST_OPEN;
              barrier_open_q <= 1'b1;
            end else begin
              state_q  <= ST_DENY;
              denied_q <= 1'b1;
            end
          end else if (timer_q == TAG_LAST) begin
            state_q       <= ST_DENY;
            denied_q      <= 1'b1;
            timeout_err_q <= 1'b1;
            timer_q       <= '0;
          end
        end
        ST_OPEN: begin
          if (pass_rise) begin
            state_q     <= ST_PULSE;
            car_pulse_q <= 1'b1;
            timer_q     <= '0;
          end else if (timer_q == OPEN_LAST) begin
            state_q       <= ST_CLOSE;
            timeout_err_q <= 1'b1;
            timer_q       <= '0;
          end
        end
        ST_PULSE: begin
          if (timer_q == PULSE_LAST) begin
            state_q     <= ST_CLOSE;
            car_pulse_q <= 1'b0;
            timer_q     <= '0;
          end
        end
        ST_CLOSE: begin
          if (!loop_db && !pass_db) begin
            state_q        <= ST_IDLE;
            barrier_open_q <= 1'b0;
            car_is_uni_q   <= 1'b0;
            timer_q        <= '0;
          end
        end
        ST_DENY: begin
          if (!loop_db) begin
            state_q      <= ST_IDLE;
            denied_q     <= 1'b0;
            car_is_uni_q <= 1'b0;
            timer_q      <= '0;
          end
        end
        default: begin
          state_q        <= ST_IDLE;
          barrier_open_q <= 1'b0;
          car_pulse_q    <= 1'b0;
          car_is_uni_q   <= 1'b0;
          denied_q       <= 1'b0;
          timer_q        <= '0;
        end
      endcase
    end
  end

  assign barrier_open = barrier_open_q;
  assign car_pulse    = car_pulse_q;
  assign car_is_uni   = car_is_uni_q;
  assign denied       = denied_q;
  assign timeout_err  = timeout_err_q;
  assign tailgate     = tailgate_q;
  assign state_o      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_parking_gate.sv
`default_nettype none
// tb_parking_gate: directed stimulus on an entry and an exit lane, checked against a behavioural model.
module tb_parking_gate;

  localparam int D  = 4;
  localparam int TT = 20;
  localparam int OT = 50;
  localparam int PC = 3;

  localparam int S_IDLE  = 0;
  localparam int S_CHECK = 1;
  localparam int S_OPEN  = 2;
  localparam int S_PULSE = 3;
  localparam int S_CLOSE = 4;
  localparam int S_DENY  = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic loop_r [2];
  logic pass_r [2];
  logic tv     [2];
  logic tu     [2];
  logic su     [2];
  logic sf     [2];
  logic bar_o  [2];
  logic cp_o   [2];
  logic cu_o   [2];
  logic dn_o   [2];
  logic te_o   [2];
  logic tg_o   [2];
  logic [2:0] st_o [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  parking_gate #(.IS_EXIT(1'b0), .DEBOUNCE_CYCLES(D), .TAG_TIMEOUT(TT),
                 .OPEN_TIMEOUT(OT), .PULSE_CYCLES(PC)) dut (
    .clock(clock), .reset(reset), .loop_raw(loop_r[0]), .pass_raw(pass_r[0]),
    .tag_valid(tv[0]), .tag_is_uni(tu[0]), .space_uni(su[0]), .space_free(sf[0]),
    .barrier_open(bar_o[0]), .car_pulse(cp_o[0]), .car_is_uni(cu_o[0]),
    .denied(dn_o[0]), .timeout_err(te_o[0]), .tailgate(tg_o[0]), .state_o(st_o[0])
  );

  parking_gate #(.IS_EXIT(1'b1), .DEBOUNCE_CYCLES(D), .TAG_TIMEOUT(TT),
                 .OPEN_TIMEOUT(OT), .PULSE_CYCLES(PC)) dut_x (
    .clock(clock), .reset(reset), .loop_raw(loop_r[1]), .pass_raw(pass_r[1]),
    .tag_valid(tv[1]), .tag_is_uni(tu[1]), .space_uni(su[1]), .space_free(sf[1]),
    .barrier_open(bar_o[1]), .car_pulse(cp_o[1]), .car_is_uni(cu_o[1]),
    .denied(dn_o[1]), .timeout_err(te_o[1]), .tailgate(tg_o[1]), .state_o(st_o[1])
  );

  // ---------------- behavioural model ----------------
  int          m_st    [2];
  int          m_enter [2];
  bit          m_uni   [2];
  bit          m_te    [2];
  bit          m_tg    [2];
  bit          m_ldb   [2];
  bit          m_pdb   [2];
  bit          m_pprev [2];
  logic [15:0] m_lh    [2];
  logic [15:0] m_ph    [2];
  int          cyc;
  bit          m_rise;
  bit          m_adm;
  int          m_el;

  // A debounced sensor flips only when the last D synchronized samples
  // (raw delayed by two clocks) all disagree with it.
  function automatic bit deb(input logic [15:0] h, input bit cur);
    for (int k = 2; k <= D + 1; k++) if (h[k] == cur) return cur;
    return !cur;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc = 0;
      for (int l = 0; l < 2; l++) begin
        m_st[l] = S_IDLE; m_enter[l] = 0; m_uni[l] = 0; m_te[l] = 0; m_tg[l] = 0;
        m_ldb[l] = 0; m_pdb[l] = 0; m_pprev[l] = 0; m_lh[l] = '0; m_ph[l] = '0;
      end
    end else begin
      cyc = cyc + 1;
      for (int l = 0; l < 2; l++) begin
        m_rise = m_pdb[l] && !m_pprev[l];
        m_te[l] = 0;
        m_tg[l] = m_rise && (m_st[l] != S_OPEN);
        m_el = cyc - m_enter[l];
        m_adm = (l == 1) || (tu[l] ? su[l] : sf[l]);
        case (m_st[l])
          S_IDLE:  if (m_ldb[l]) begin m_st[l] = S_CHECK; m_enter[l] = cyc; end
          S_CHECK: begin
            if (!m_ldb[l]) begin m_st[l] = S_IDLE; m_enter[l] = cyc; end
            else if (tv[l]) begin
              m_uni[l] = tu[l]; m_st[l] = m_adm ? S_OPEN : S_DENY; m_enter[l] = cyc;
            end else if (m_el == TT) begin
              m_st[l] = S_DENY; m_te[l] = 1; m_enter[l] = cyc;
            end
          end
          S_OPEN: begin
            if (m_rise) begin m_st[l] = S_PULSE; m_enter[l] = cyc; end
            else if (m_el == OT) begin m_st[l] = S_CLOSE; m_te[l] = 1; m_enter[l] = cyc; end
          end
          S_PULSE: if (m_el == PC) begin m_st[l] = S_CLOSE; m_enter[l] = cyc; end
          S_CLOSE: if (!m_ldb[l] && !m_pdb[l]) begin m_st[l] = S_IDLE; m_enter[l] = cyc; end
          S_DENY:  if (!m_ldb[l]) begin m_st[l] = S_IDLE; m_enter[l] = cyc; end
          default: m_st[l] = S_IDLE;
        endcase
        if (m_st[l] == S_IDLE) m_uni[l] = 0;
        m_pprev[l] = m_pdb[l];
        m_lh[l] = {m_lh[l][14:0], loop_r[l]};
        m_ph[l] = {m_ph[l][14:0], pass_r[l]};
        m_ldb[l] = deb(m_lh[l], m_ldb[l]);
        m_pdb[l] = deb(m_ph[l], m_pdb[l]);
      end
    end
  end

  // ---------------- per-cycle compare and event counters ----------------
  logic [8:0] ce;
  logic [8:0] ca;
  int pulses [2];
  int terrs  [2];
  int tgs    [2];
  int barc   [2];
  bit cp_prev[2];

  initial begin
    for (int l = 0; l < 2; l++) begin
      pulses[l] = 0; terrs[l] = 0; tgs[l] = 0; barc[l] = 0; cp_prev[l] = 0;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      for (int l = 0; l < 2; l++) begin
        ce = {(m_st[l] == S_OPEN || m_st[l] == S_PULSE || m_st[l] == S_CLOSE),
              (m_st[l] == S_PULSE), m_uni[l], (m_st[l] == S_DENY), m_te[l], m_tg[l],
              3'(m_st[l])};
        ca = {bar_o[l], cp_o[l], cu_o[l], dn_o[l], te_o[l], tg_o[l], st_o[l]};
        n_chk++;
        if (ca !== ce) begin
          n_err++;
          $display("FAIL model lane%0d @%0t: outputs {bar,pulse,uni,den,terr,tg,st}=%b required %b",
                   l, $time, ca, ce);
        end
      end
    end
    for (int l = 0; l < 2; l++) begin
      if (cp_o[l] === 1'b1 && !cp_prev[l]) pulses[l]++;
      cp_prev[l] = (cp_o[l] === 1'b1);
      if (te_o[l] === 1'b1) terrs[l]++;
      if (tg_o[l] === 1'b1) tgs[l]++;
      if (bar_o[l] === 1'b1) barc[l]++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic tag(input int l, input bit uni, input bit spu, input bit spf);
    tv[l] = 1; tu[l] = uni; su[l] = spu; sf[l] = spf;
    tick(1);
    tv[l] = 0; tu[l] = 0; su[l] = 0; sf[l] = 0;
  endtask

  int b_p, b_t, b_g, b_b;

  initial begin
    for (int l = 0; l < 2; l++) begin
      loop_r[l] = 0; pass_r[l] = 0; tv[l] = 0; tu[l] = 0; su[l] = 0; sf[l] = 0;
    end
    tick(2);
    reset = 0;
    tick(1);
    chk("reset_outputs", {bar_o[0], cp_o[0], cu_o[0], dn_o[0], te_o[0], tg_o[0]}, 0);
    chk("reset_state", st_o[0], S_IDLE);

    // 1. admitted uni car on the entry lane
    b_p = pulses[0];
    loop_r[0] = 1; tick(10);
    chk("t1_check", st_o[0], S_CHECK);
    tag(0, 1, 1, 0);
    chk("t1_barrier_after_tag", bar_o[0], 1);
    tick(9);
    pass_r[0] = 1;
    tick(6); chk("t1_pulse_not_yet", cp_o[0], 0);
    tick(1); chk("t1_pulse_start", cp_o[0], 1); chk("t1_uni", cu_o[0], 1);
    tick(2); chk("t1_pulse_third", cp_o[0], 1);
    tick(1); chk("t1_pulse_end", cp_o[0], 0); chk("t1_close", st_o[0], S_CLOSE);
    loop_r[0] = 0; pass_r[0] = 0;
    tick(10);
    chk("t1_barrier_down", bar_o[0], 0); chk("t1_idle", st_o[0], S_IDLE);
    chk("t1_one_pulse", pulses[0] - b_p, 1);

    // 2. free tag with no free space
    b_b = barc[0]; b_p = pulses[0];
    loop_r[0] = 1; tick(10);
    tag(0, 0, 1, 0);
    chk("t2_denied", dn_o[0], 1); chk("t2_deny_state", st_o[0], S_DENY);
    tick(5);
    loop_r[0] = 0; tick(10);
    chk("t2_denied_clear", dn_o[0], 0); chk("t2_idle", st_o[0], S_IDLE);
    chk("t2_no_barrier", barc[0] - b_b, 0); chk("t2_no_pulse", pulses[0] - b_p, 0);

    // 3. tag timeout, then a tag arriving in the timeout cycle
    b_t = terrs[0];
    loop_r[0] = 1; tick(40);
    chk("t3_timeout_once", terrs[0] - b_t, 1); chk("t3_deny", st_o[0], S_DENY);
    loop_r[0] = 0; tick(10);
    chk("t3_idle", st_o[0], S_IDLE);
    b_t = terrs[0];
    loop_r[0] = 1; tick(26);
    tag(0, 1, 1, 0);
    chk("t3_late_tag_open", st_o[0], S_OPEN); chk("t3_no_timeout", terrs[0] - b_t, 0);

    // 4. open timeout with no pass
    b_p = pulses[0];
    tick(55);
    chk("t4_timeout", terrs[0] - b_t, 1); chk("t4_close", st_o[0], S_CLOSE);
    chk("t4_no_pulse", pulses[0] - b_p, 0); chk("t4_barrier_held", bar_o[0], 1);
    loop_r[0] = 0; tick(10);
    chk("t4_idle", st_o[0], S_IDLE);

    // 5. glitches, idle tag, tailgate
    b_g = tgs[0];
    for (int i = 0; i < 2; i++) begin
      loop_r[0] = 1; tick(3); loop_r[0] = 0; tick(5);
    end
    tag(0, 1, 1, 1);
    tick(10);
    chk("t5_glitch_idle", st_o[0], S_IDLE);
    pass_r[0] = 1; tick(3); pass_r[0] = 0; tick(10);
    chk("t5_no_tailgate", tgs[0] - b_g, 0);
    pass_r[0] = 1; tick(6); pass_r[0] = 0; tick(12);
    chk("t5_tailgate_once", tgs[0] - b_g, 1); chk("t5_still_idle", st_o[0], S_IDLE);

    // 6. reset during the pulse, then exit lane admits with no space
    loop_r[0] = 1; tick(10);
    tag(0, 1, 1, 0);
    tick(5);
    pass_r[0] = 1; tick(8);
    chk("t6_in_pulse", cp_o[0], 1);
    #2 reset = 1;
    #1;
    chk("t6_async_pulse", cp_o[0], 0); chk("t6_async_barrier", bar_o[0], 0);
    chk("t6_async_uni", cu_o[0], 0);
    loop_r[0] = 0; pass_r[0] = 0;
    tick(1);
    reset = 0;
    tick(1);
    chk("t6_idle_after_reset", st_o[0], S_IDLE);

    b_p = pulses[1];
    loop_r[1] = 1; tick(10);
    tag(1, 0, 0, 0);
    chk("t6_exit_open", st_o[1], S_OPEN); chk("t6_exit_barrier", bar_o[1], 1);
    tick(3);
    pass_r[1] = 1; tick(7);
    chk("t6_exit_pulse", cp_o[1], 1); chk("t6_exit_free", cu_o[1], 0);
    loop_r[1] = 0; pass_r[1] = 0; tick(12);
    chk("t6_exit_idle", st_o[1], S_IDLE); chk("t6_exit_one_pulse", pulses[1] - b_p, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
